line_raster_writer: RTL and testbench
=====================================

Name: line_raster_writer

Overview:
- Bresenham line rasterizer on the write side of the frame buffer. Accepts one line command (two endpoints plus a colour) through a valid/ready handshake.
- Walks every pixel of the line in all eight octants. Emits one framebuffer write per on-screen pixel through a second valid/ready handshake into the pixel/BRAM write arbiter.
- Pixel sprites consume buffer contents on the scan side; this block produces them.

Parameters:
- FB_WIDTH, 320, framebuffer width in pixels; x >= FB_WIDTH is off-screen.
- FB_HEIGHT, 180, framebuffer height in pixels; y >= FB_HEIGHT is off-screen.
- ADDR_WIDTH, 16, width of the linear write address.
- COLOR_WIDTH, 16, width of the pixel colour word.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- cmd_valid_in  input  1  line command valid
- cmd_ready_out  output  1  block can accept a command (high only in IDLE)
- x0_in  input  11  start x, unsigned
- y0_in  input  10  start y, unsigned
- x1_in  input  11  end x, unsigned
- y1_in  input  10  end y, unsigned
- color_in  input  COLOR_WIDTH  line colour
- pix_valid_out  output  1  write request valid
- pix_ready_in  input  1  downstream accepts write
- pix_x_out  output  11  current pixel x
- pix_y_out  output  10  current pixel y
- pix_addr_out  output  ADDR_WIDTH  pix_y_out*FB_WIDTH + pix_x_out, truncated to ADDR_WIDTH
- pix_color_out  output  COLOR_WIDTH  latched colour
- busy_out  output  1  high in SETUP/DRAW/DONE
- done_out  output  1  one-cycle pulse when a line completes

Behaviour:
- Reset (sync, rst_in high at a clock edge):
  - State becomes IDLE; cmd_ready_out=1.
  - pix_valid_out=0, busy_out=0, done_out=0.
  - pix_x_out, pix_y_out, pix_addr_out and pix_color_out all become 0.
  - A reset mid-line abandons the line: no done_out pulse, no further writes.
- IDLE:
  - cmd_ready_out=1.
  - On cmd_valid_in && cmd_ready_out, latch endpoints and colour, then go to SETUP.
  - cmd_valid_in is ignored outside IDLE.
- SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx + dy.
  - Current point (cx,cy) = (x0,y0).
  - Widths: dx, dy and err are 13-bit signed; e2 is 14-bit signed. No overflow is possible for 11/10-bit inputs.
  - Go to DRAW.
- DRAW:
  - Current point drives pix_x_out/pix_y_out; pix_addr_out derives combinationally from them.
  - On-screen means cx<FB_WIDTH && cy<FB_HEIGHT.
  - If on-screen: pix_valid_out=1. The point advances only on pix_valid_out && pix_ready_in. All pix_* outputs hold stable while pix_valid_out && !pix_ready_in.
  - If off-screen: pix_valid_out=0. The point advances unconditionally after one cycle (clip skip).
  - Advance rule, with e2 = 2*err and both tests using the pre-update err:
    - if e2 >= dy: err += dy, cx += sx
    - if e2 <= dx: err += dx, cy += sy
    - both updates may apply in the same cycle
  - If the point being accepted or skipped equals (x1,y1), go to DONE instead of advancing.
- DONE (1 cycle): done_out=1, pix_valid_out=0, then IDLE.
- Counts and timing:
  - Exactly max(dx,|dy|)+1 points are visited per line.
  - A degenerate line (x0==x1, y0==y1) visits exactly one point.
  - Latency from command handshake to first pix_valid_out is 2 cycles.
  - With pix_ready_in tied high, throughput is 1 pixel/cycle.
  - done_out asserts the cycle after the last accept or skip.
  - A back-to-back command is accepted at the earliest 1 cycle after done_out.

Test Plan:
- Horizontal, ready tied high: (0,0)->(4,0) -> 5 writes, x=0..4, addr=0..4; done_out one cycle after the 5th; cmd_ready_out high the following cycle.
- Steep negative octant: (3,5)->(1,0) -> writes in order (3,5),(3,4),(2,3),(2,2),(1,1),(1,0); addr of (2,3) = 962; exactly 6 writes.
- Backpressure: (10,10)->(12,12) with pix_ready_in low for 3 cycles on the 2nd pixel -> (11,11), addr 3531, held stable for 3 cycles; 3 writes total; no pixel dropped or duplicated.
- Clipping: (318,10)->(322,10) -> writes only x=318 and x=319; the 3 off-screen points are skipped at one cycle each; done_out still pulses once.
- Degenerate, then reset: (7,7)->(7,7) -> one write, addr 2247, then done. Next, start (0,0)->(100,50) and assert rst_in after 4 writes -> pix_valid_out=0 next cycle; no done_out pulse; cmd_ready_out=1.

Source files
------------

// File: rtl/line_raster_writer.sv
// Bresenham line rasterizer: takes one line command, walks every pixel in any octant
// and issues one framebuffer write per on-screen pixel over a valid/ready handshake.
module line_raster_writer #(
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned FB_HEIGHT   = 180,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned COLOR_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   cmd_valid_in,
    output logic                   cmd_ready_out,
    input  logic [10:0]            x0_in,
    input  logic [9:0]             y0_in,
    input  logic [10:0]            x1_in,
    input  logic [9:0]             y1_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    output logic                   pix_valid_out,
    input  logic                   pix_ready_in,
    output logic [10:0]            pix_x_out,
    output logic [9:0]             pix_y_out,
    output logic [ADDR_WIDTH-1:0]  pix_addr_out,
    output logic [COLOR_WIDTH-1:0] pix_color_out,
    output logic                   busy_out,
    output logic                   done_out
);

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;
    localparam int unsigned D_W = 13;
    localparam int unsigned E_W = 14;
    localparam int unsigned P_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [X_W-1:0]         start_x;
    logic [Y_W-1:0]         start_y;
    logic [X_W-1:0]         end_x;
    logic [Y_W-1:0]         end_y;
    logic [X_W-1:0]         cx;
    logic [Y_W-1:0]         cy;
    logic [COLOR_WIDTH-1:0] color;
    logic signed [D_W-1:0]  dx;
    logic signed [D_W-1:0]  dy;
    logic signed [D_W-1:0]  err;
    logic                   sx_neg;
    logic                   sy_neg;

    logic signed [D_W-1:0]  dx_abs;
    logic signed [D_W-1:0]  dy_neg;
    logic signed [E_W-1:0]  e2;
    logic signed [E_W-1:0]  dx_ext;
    logic signed [E_W-1:0]  dy_ext;
    logic signed [D_W-1:0]  err_dx;
    logic signed [D_W-1:0]  err_dy;
    logic signed [D_W-1:0]  err_next;
    logic                   step_x;
    logic                   step_y;
    logic                   on_screen;
    logic                   at_end;
    logic                   advance;

    // Stepping decisions for the current point; both tests use the pre-update error.
    always_comb begin
        dx_abs    = (start_x < end_x) ? D_W'(end_x - start_x) : D_W'(start_x - end_x);
        dy_neg    = (start_y < end_y) ? -D_W'(end_y - start_y) : -D_W'(start_y - end_y);
        e2        = {err, 1'b0};
        dx_ext    = E_W'(dx);
        dy_ext    = E_W'(dy);
        step_x    = (e2 >= dy_ext);
        step_y    = (e2 <= dx_ext);
        err_dy    = step_x ? dy : '0;
        err_dx    = step_y ? dx : '0;
        err_next  = err + err_dy + err_dx;
        on_screen = (P_W'(cx) < FB_WIDTH) && (P_W'(cy) < FB_HEIGHT);
        at_end    = (cx == end_x) && (cy == end_y);
        // Off-screen points are skipped after one cycle without waiting for the sink.
        advance   = (state == DRAW) && (on_screen ? pix_ready_in : 1'b1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid_in) state_next = SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (advance && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_out = 1'b0;
        pix_valid_out = 1'b0;
        busy_out      = 1'b1;
        done_out      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_out = 1'b1;
                busy_out      = 1'b0;
            end
            DRAW:    pix_valid_out = on_screen;
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            start_x <= '0;
            start_y <= '0;
            end_x   <= '0;
            end_y   <= '0;
            cx      <= '0;
            cy      <= '0;
            color   <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_in) begin
                        start_x <= x0_in;
                        start_y <= y0_in;
                        end_x   <= x1_in;
                        end_y   <= y1_in;
                        color   <= color_in;
                    end
                end
                SETUP: begin
                    dx     <= dx_abs;
                    dy     <= dy_neg;
                    err    <= dx_abs + dy_neg;
                    sx_neg <= !(start_x < end_x);
                    sy_neg <= !(start_y < end_y);
                    cx     <= start_x;
                    cy     <= start_y;
                end
                DRAW: begin
                    if (advance && !at_end) begin
                        err <= err_next;
                        if (step_x) cx <= sx_neg ? cx - X_W'(1) : cx + X_W'(1);
                        if (step_y) cy <= sy_neg ? cy - Y_W'(1) : cy + Y_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_x_out     = cx;
    assign pix_y_out     = cy;
    assign pix_color_out = color;
    assign pix_addr_out  = ADDR_WIDTH'(P_W'(cy) * P_W'(FB_WIDTH) + P_W'(cx));

endmodule

// File: tb/tb_line_raster_writer.sv
// Self-checking bench for line_raster_writer: directed table of lines plus random lines
// with random backpressure, compared against a point-list model of the rasterizer.
module tb_line_raster_writer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [10:0] x0_in;
    logic [9:0]  y0_in;
    logic [10:0] x1_in;
    logic [9:0]  y1_in;
    logic [15:0] color_in;
    logic        pix_valid_out;
    logic        pix_ready_in;
    logic [10:0] pix_x_out;
    logic [9:0]  pix_y_out;
    logic [15:0] pix_addr_out;
    logic [15:0] pix_color_out;
    logic        busy_out;
    logic        done_out;

    line_raster_writer #(
        .FB_WIDTH(320), .FB_HEIGHT(180), .ADDR_WIDTH(16), .COLOR_WIDTH(16)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
        .color_in(color_in),
        .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
        .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
        .pix_addr_out(pix_addr_out), .pix_color_out(pix_color_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int x;
        int y;
        int addr;
    } wr_t;

    typedef struct {
        int x0; int y0; int x1; int y1;
        int mode; int stall_idx; int stall_n;
        int exp_writes; int exp_first; int exp_last;
    } vec_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  checks = 0;
    int  errors = 0;
    int  last_stalls;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Ordered list of visible pixels for a line, straight from the integer Bresenham rules.
    function automatic void model_line(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        wr_t w;
        exp_q.delete();
        dx = iabs(x1 - x0);
        dy = -iabs(y1 - y0);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        forever begin
            if (x < 320 && y < 180) begin
                w.x = x; w.y = y; w.addr = (y * 320 + x) & 16'hFFFF;
                exp_q.push_back(w);
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // mode 0: sink always ready, 1: stall_n cycles on write stall_idx, 2: random ready.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] col, input int mode, input int stall_idx,
                            input int stall_n, input int abort_after);
        int cyc, stalls, wr, scnt, npts, bad;
        bit seen_done, prev_hold, r;
        logic [10:0] hx;
        logic [9:0]  hy;
        logic [15:0] ha;
        wr_t g;
        model_line(x0, y0, x1, y1);
        npts = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
        got_q.delete();
        @(negedge clk_in);
        chk("cmd_ready_idle", cmd_ready_out, 1);
        cmd_valid_in = 1'b1;
        x0_in = 11'(x0); y0_in = 10'(y0); x1_in = 11'(x1); y1_in = 10'(y1);
        color_in = col;
        pix_ready_in = 1'b1;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
        x0_in = 11'($urandom); y0_in = 10'($urandom); color_in = 16'($urandom);
        chk("setup_valid", pix_valid_out, 0);
        chk("setup_busy", busy_out, 1);
        cyc = 1; stalls = 0; wr = 0; scnt = 0; seen_done = 0; prev_hold = 0;
        hx = '0; hy = '0; ha = '0;
        while (!seen_done && cyc < 5000) begin
            @(negedge clk_in);
            cyc++;
            if (done_out) begin
                seen_done = 1;
                cmd_valid_in = 1'b0;
                break;
            end
            if (mode == 2) begin
                cmd_valid_in = 1'($urandom_range(0, 1));
                x1_in = 11'($urandom); y1_in = 10'($urandom);
            end
            if (prev_hold) begin
                chk("hold_valid", pix_valid_out, 1);
                chk("hold_xy", {pix_x_out, pix_y_out}, {hx, hy});
                chk("hold_addr", pix_addr_out, ha);
                chk("hold_color", pix_color_out, col);
            end
            r = 1'b1;
            if (mode == 1) begin
                if (pix_valid_out && wr == stall_idx && scnt < stall_n) begin
                    r = 1'b0;
                    scnt++;
                end
            end else if (mode == 2) begin
                r = ($urandom_range(0, 3) != 0);
            end
            pix_ready_in = r;
            prev_hold = 0;
            if (pix_valid_out) begin
                if (!r) begin
                    stalls++;
                    prev_hold = 1;
                    hx = pix_x_out; hy = pix_y_out; ha = pix_addr_out;
                end else begin
                    g.x = int'(pix_x_out); g.y = int'(pix_y_out); g.addr = int'(pix_addr_out);
                    got_q.push_back(g);
                    if (wr < exp_q.size()) begin
                        chk("pix_x", g.x, exp_q[wr].x);
                        chk("pix_y", g.y, exp_q[wr].y);
                        chk("pix_addr", g.addr, exp_q[wr].addr);
                        chk("pix_color", pix_color_out, col);
                    end else begin
                        chk("extra_write", wr, exp_q.size());
                    end
                    wr++;
                    if (abort_after > 0 && wr == abort_after) begin
                        @(negedge clk_in);
                        rst_in = 1'b1;
                        pix_ready_in = 1'b0;
                        cmd_valid_in = 1'b0;
                        @(negedge clk_in);
                        rst_in = 1'b0;
                        chk("abort_valid", pix_valid_out, 0);
                        chk("abort_ready", cmd_ready_out, 1);
                        chk("abort_busy", busy_out, 0);
                        chk("abort_done", done_out, 0);
                        chk("abort_addr", pix_addr_out, 0);
                        bad = 0;
                        repeat (6) begin
                            @(negedge clk_in);
                            if (done_out || pix_valid_out) bad++;
                        end
                        chk("abort_quiet", bad, 0);
                        return;
                    end
                end
            end
        end
        last_stalls = stalls;
        chk("done_seen", seen_done, 1);
        chk("line_cycles", cyc, npts + stalls + 2);
        chk("write_count", wr, exp_q.size());
        chk("done_valid", pix_valid_out, 0);
        pix_ready_in = 1'b1;
        @(negedge clk_in);
        chk("post_done", done_out, 0);
        chk("post_ready", cmd_ready_out, 1);
        chk("post_busy", busy_out, 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{x0:0,  y0:0,  x1:4,   y1:0,  mode:0, stall_idx:0, stall_n:0,
                   exp_writes:5, exp_first:0,    exp_last:4};
        tbl[1] = '{x0:3,  y0:5,  x1:1,   y1:0,  mode:0, stall_idx:0, stall_n:0,
                   exp_writes:6, exp_first:1603, exp_last:1};
        tbl[2] = '{x0:10, y0:10, x1:12,  y1:12, mode:1, stall_idx:1, stall_n:3,
                   exp_writes:3, exp_first:3210, exp_last:3852};
        tbl[3] = '{x0:318, y0:10, x1:322, y1:10, mode:0, stall_idx:0, stall_n:0,
                   exp_writes:2, exp_first:3518, exp_last:3519};
        tbl[4] = '{x0:7,  y0:7,  x1:7,   y1:7,  mode:0, stall_idx:0, stall_n:0,
                   exp_writes:1, exp_first:2247, exp_last:2247};

        rst_in = 1'b1; cmd_valid_in = 1'b0; pix_ready_in = 1'b1;
        x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0; color_in = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_ready", cmd_ready_out, 1);
        chk("rst_valid", pix_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_xy", {pix_x_out, pix_y_out}, 0);
        chk("rst_addr", pix_addr_out, 0);
        chk("rst_color", pix_color_out, 0);
        rst_in = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, 16'(16'hA500 + i),
                     tbl[i].mode, tbl[i].stall_idx, tbl[i].stall_n, 0);
            chk("tbl_writes", got_q.size(), tbl[i].exp_writes);
            if (got_q.size() > 0) begin
                chk("tbl_first_addr", got_q[0].addr, tbl[i].exp_first);
                chk("tbl_last_addr", got_q[got_q.size()-1].addr, tbl[i].exp_last);
            end
            if (i == 1 && got_q.size() > 2) begin
                chk("steep_pt2_xy", {got_q[2].x[15:0], got_q[2].y[15:0]}, {16'd2, 16'd3});
                chk("steep_pt2_addr", got_q[2].addr, 962);
            end
            if (i == 2 && got_q.size() > 1) begin
                chk("bp_pt1_addr", got_q[1].addr, 3531);
                chk("bp_stalls", last_stalls, 3);
            end
        end

        run_line(0, 0, 100, 50, 16'h1234, 0, 0, 0, 4);
        chk("abort_writes", got_q.size(), 4);

        for (int n = 0; n < 40; n++) begin
            run_line(int'($urandom_range(0, 360)), int'($urandom_range(0, 210)),
                     int'($urandom_range(0, 360)), int'($urandom_range(0, 210)),
                     16'($urandom), 2, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
